vthernet_rx_ring_buffer: RTL

//  Multi-slot RX frame buffer between the Vthernet MAC receive byte stream and the Wishbone bus.

---
 rtl/vthernet_rx_ring_buffer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/vthernet_rx_ring_buffer.sv
// Multi-slot receive frame ring between the Vthernet MAC byte stream and a
// Wishbone slave exposing status, head-frame length and head-frame data.
module vthernet_rx_ring_buffer #(
    parameter int          NUM_SLOTS  = 4,
    parameter int          SLOT_BYTES = 512,
    parameter logic [31:0] ADDR_BASE  = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_last,
    input  logic        rx_err,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        rx_irq
);
    localparam int SLOT_AW = $clog2(NUM_SLOTS);
    localparam int BYTE_AW = $clog2(SLOT_BYTES);
    localparam int WORD_AW = SLOT_AW + BYTE_AW - 2;
    localparam int CNT_W   = SLOT_AW + 1;
    localparam int LEN_W   = BYTE_AW + 1;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(NUM_SLOTS);
    localparam logic [LEN_W-1:0] SLOT_LIMIT = LEN_W'(SLOT_BYTES);

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    state_t             state, state_nxt;
    logic [LEN_W-1:0]   byte_cnt, byte_cnt_nxt;
    logic [LEN_W-1:0]   wr_byte, commit_len;
    logic [SLOT_AW-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [15:0]        drop_cnt;
    logic               irq_en;
    logic               byte_we, commit, discard, full;
    logic [WORD_AW-1:0] waddr, raddr;

    logic [31:0]        mem [0:(NUM_SLOTS*SLOT_BYTES/4)-1];
    logic [LEN_W-1:0]   len [0:NUM_SLOTS-1];

    logic [12:0]        off;
    logic               in_win, req, is_data, release_ok, ctrl_wr;
    logic [31:0]        rd_val, rdat_p1, mem_p1;
    logic               dsel_p1;
    logic               unused_bits;

    assign unused_bits = ^{wbs_sel_i, wbs_dat_i[31:2]};

    assign full       = (count == FULL_COUNT);
    assign wr_byte    = (state == RECV) ? byte_cnt : '0;
    assign commit_len = wr_byte + LEN_W'(1);
    assign waddr      = {wr_ptr, wr_byte[BYTE_AW-1:2]};

    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        byte_we      = 1'b0;
        commit       = 1'b0;
        discard      = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (full || rx_err) begin
                        discard   = 1'b1;
                        state_nxt = rx_last ? IDLE : DROP;
                    end else begin
                        byte_we      = 1'b1;
                        byte_cnt_nxt = LEN_W'(1);
                        if (rx_last) commit = 1'b1;
                        else         state_nxt = RECV;
                    end
                end
            end
            RECV: begin
                // A byte arriving with byte_cnt at the slot size would spill into the next slot.
                if (rx_valid) begin
                    if (rx_err || byte_cnt == SLOT_LIMIT) begin
                        discard   = 1'b1;
                        state_nxt = rx_last ? IDLE : DROP;
                    end else begin
                        byte_we      = 1'b1;
                        byte_cnt_nxt = byte_cnt + LEN_W'(1);
                        if (rx_last) begin
                            commit    = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            DROP: begin
                if (!rx_valid || rx_last) state_nxt = IDLE;
            end
            default: state_nxt = DROP;
        endcase
    end

    assign off        = wbs_adr_i[12:0];
    assign in_win     = (wbs_adr_i[31:13] == ADDR_BASE[31:13]);
    assign req        = wbs_stb_i & wbs_cyc_i & in_win & ~wbs_ack_o;
    assign is_data    = off[12] && ({1'b0, off[11:0]} < 13'(SLOT_BYTES));
    assign release_ok = req & wbs_we_i & (off == 13'h008) & (count != '0);
    assign ctrl_wr    = req & wbs_we_i & (off == 13'h00C);
    assign raddr      = {rd_ptr, off[BYTE_AW-1:2]};

    always_comb begin
        rd_val = '0;
        case (off)
            13'h000: rd_val = {drop_cnt, 4'h0, 4'(rd_ptr), 3'b000, 5'(count)};
            13'h004: rd_val = (count == '0) ? '0 : 32'(len[rd_ptr]);
            13'h00C: rd_val = {31'b0, irq_en};
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= DROP;
            byte_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
            irq_en   <= 1'b0;
            rx_irq   <= 1'b0;
        end else begin
            state    <= state_nxt;
            byte_cnt <= byte_cnt_nxt;
            if (commit)     wr_ptr <= wr_ptr + SLOT_AW'(1);
            if (release_ok) rd_ptr <= rd_ptr + SLOT_AW'(1);
            count <= count + CNT_W'(commit) - CNT_W'(release_ok);
            if (ctrl_wr) irq_en <= wbs_dat_i[0];
            if (ctrl_wr && wbs_dat_i[1])
                drop_cnt <= '0;
            else if (discard && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
            rx_irq <= irq_en & (count != '0);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (byte_we) mem[waddr][{wr_byte[1:0], 3'b000} +: 8] <= rx_data;
        if (commit)  len[wr_ptr] <= commit_len;
    end

    // Bus response stage: request accepted on this edge, data returned with ack.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            dsel_p1   <= 1'b0;
        end else begin
            wbs_ack_o <= req;
            dsel_p1   <= req & ~wbs_we_i & is_data;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        rdat_p1 <= (req & ~wbs_we_i) ? rd_val : '0;
        mem_p1  <= mem[raddr];
    end

    assign wbs_dat_o = wbs_ack_o ? (dsel_p1 ? mem_p1 : rdat_p1) : '0;

endmodule
